// File: rtl/pwrup_reset_sequencer.sv
// Power-up reset sequencer: synchronises rst_n into clk_in, holds, then releases NUM_CH resets with a stagger.
// Optional soft-reset input sw_rst_req is compiled in with `define SOFT_RST_EN.
module pwrup_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int NUM_CH         = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic              clk_in,
  input  logic              rst_n,
`ifdef SOFT_RST_EN
  input  logic              sw_rst_req,
`endif
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              ready
);

  localparam int MAX_CYC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int CH_W    = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [CH_W-1:0]        ch, ch_nxt;
  logic [NUM_CH-1:0]      rst_n_out_nxt;
  logic                   ready_nxt;
  logic                   hold_done, stag_done, last_ch;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync      = sync_q[SYNC_STAGES-1];
  assign hold_done = (cnt == CNT_W'(HOLD_CYCLES - 1));
  assign stag_done = (cnt == CNT_W'(STAGGER_CYCLES - 1));
  assign last_ch   = (ch == CH_W'(NUM_CH - 1));

  // Outputs are registered alongside the state so every reset line comes straight from a flop.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RESET;
      cnt       <= '0;
      ch        <= '0;
      rst_n_out <= '0;
      ready     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ch        <= ch_nxt;
      rst_n_out <= rst_n_out_nxt;
      ready     <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET:   if (sync) state_nxt = ST_HOLD;
      ST_HOLD:    if (hold_done) state_nxt = (NUM_CH == 1) ? ST_RUN : ST_RELEASE;
      ST_RELEASE: if (stag_done && last_ch) state_nxt = ST_RUN;
      ST_RUN:     state_nxt = ST_RUN;
      default:    state_nxt = sync ? ST_HOLD : ST_RESET;
    endcase
`ifdef SOFT_RST_EN
    if (sw_rst_req && (state == ST_HOLD || state == ST_RELEASE || state == ST_RUN))
      state_nxt = ST_HOLD;
`endif
  end

  always_comb begin
    cnt_nxt       = cnt;
    ch_nxt        = ch;
    rst_n_out_nxt = rst_n_out;
    ready_nxt     = ready;
    case (state)
      ST_HOLD: begin
        if (hold_done) begin
          rst_n_out_nxt[0] = 1'b1;
          cnt_nxt          = '0;
          ch_nxt           = CH_W'(1);
          if (NUM_CH == 1) ready_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (stag_done) begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (ch == CH_W'(i)) rst_n_out_nxt[i] = 1'b1;
          end
          cnt_nxt = '0;
          ch_nxt  = ch + 1'b1;
          if (last_ch) ready_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        cnt_nxt = cnt;
      end
      default: begin
        cnt_nxt = '0;
        ch_nxt  = '0;
      end
    endcase
`ifdef SOFT_RST_EN
    // Soft reset restarts the hold window; it is ignored until the synchroniser has released.
    if (sw_rst_req && (state == ST_HOLD || state == ST_RELEASE || state == ST_RUN)) begin
      rst_n_out_nxt = '0;
      ready_nxt     = 1'b0;
      cnt_nxt       = '0;
      ch_nxt        = '0;
    end
`endif
  end

endmodule

// File: tb/tb_pwrup_reset_sequencer.sv
// Directed bench for pwrup_reset_sequencer: default instance plus a minimal-parameter instance.
module tb_pwrup_reset_sequencer;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic [2:0] rst_n_out;
  logic       ready;
  logic [0:0] min_out;
  logic       min_ready;
`ifdef SOFT_RST_EN
  logic       sw_rst_req = 1'b0;
  logic       sw_lo      = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  pwrup_reset_sequencer u_dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
`ifdef SOFT_RST_EN
    .sw_rst_req(sw_rst_req),
`endif
    .rst_n_out (rst_n_out),
    .ready     (ready)
  );

  pwrup_reset_sequencer #(
    .SYNC_STAGES   (3),
    .NUM_CH        (1),
    .HOLD_CYCLES   (1),
    .STAGGER_CYCLES(1)
  ) u_min (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
`ifdef SOFT_RST_EN
    .sw_rst_req(sw_lo),
`endif
    .rst_n_out (min_out),
    .ready     (min_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Channel i of the default instance releases at base + 4*i.
  function automatic logic [2:0] exp_out(input int e, input int base);
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = (e >= base + 4 * i);
    return r;
  endfunction

  task automatic release_rst();
    @(posedge clk_in);
    #5;
    rst_n = 1'b1;
  endtask

  // Check edges from..to after release; soft request is high for edges sw_from..sw_to.
  task automatic walk(input int from, input int to, input int sw_from, input int sw_to);
    int base;
    for (int e = from; e <= to; e++) begin
`ifdef SOFT_RST_EN
      sw_rst_req = (e >= sw_from && e <= sw_to);
`endif
      @(posedge clk_in);
      #1;
      base = (e < sw_from) ? 19 : sw_to + 16;
      chk($sformatf("out_e%0d", e), 32'(rst_n_out), 32'(exp_out(e, base)));
      chk($sformatf("ready_e%0d", e), 32'(ready), 32'(e >= base + 8));
      chk($sformatf("min_out_e%0d", e), 32'(min_out), 32'(e >= 5));
      chk($sformatf("min_ready_e%0d", e), 32'(min_ready), 32'(e >= 5));
    end
`ifdef SOFT_RST_EN
    sw_rst_req = 1'b0;
`endif
  endtask

  initial begin
    int first;
    int viol;
    logic [2:0] prev;

    rst_n = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    chk("reset_out", 32'(rst_n_out), 32'h0);
    chk("reset_ready", 32'(ready), 32'h0);
    chk("reset_min_out", 32'(min_out), 32'h0);
    chk("reset_min_ready", 32'(min_ready), 32'h0);

    release_rst();
    walk(1, 30, 1000, 0);

    // Short asynchronous pulse in the middle of the stagger.
    rst_n = 1'b0;
    repeat (2) @(posedge clk_in);
    release_rst();
    walk(1, 24, 1000, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("pulse_out", 32'(rst_n_out), 32'h0);
    chk("pulse_ready", 32'(ready), 32'h0);
    chk("pulse_min_out", 32'(min_out), 32'h0);
    #2 rst_n = 1'b1;
    walk(1, 28, 1000, 0);

    for (int run = 0; run < 200; run++) begin
      rst_n = 1'b0;
      @(posedge clk_in);
      #($urandom_range(1, 9));
      rst_n = 1'b1;
      first = -1;
      viol  = 0;
      prev  = 3'b000;
      for (int e = 1; e <= 22; e++) begin
        @(posedge clk_in);
        #1;
        if (first < 0 && rst_n_out[0]) first = e;
        if ((prev & ~rst_n_out) != 3'b000) viol++;
        prev = rst_n_out;
      end
      chk($sformatf("phase_rel_run%0d_edge%0d", run, first), 32'(first == 19 || first == 20), 32'h1);
      chk($sformatf("phase_mono_run%0d", run), 32'(viol), 32'h0);
    end

`ifdef SOFT_RST_EN
    rst_n = 1'b0;
    repeat (2) @(posedge clk_in);
    release_rst();
    walk(1, 66, 40, 40);

    rst_n = 1'b0;
    repeat (2) @(posedge clk_in);
    release_rst();
    walk(1, 74, 40, 49);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
